ula_seq: RTL

Registered, parametrised ALU for the CPU datapath with a valid/ready handshake. It extends the combinational ULA with a generic width LARGURA, variable-distance shifts, and full N/Z/C/V flags. It adds a multi-cycle shift-add multiplier and invalid-opcode detection. It sits between the register-file read stage and write-back, and the control unit stalls on `Pronto`.

---
 rtl/ula_pkg.sv | 29 ++
 rtl/ula_mult.sv | 60 ++++++
 rtl/ula_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the registered ALU: opcodes, FSM states, flags.
package ula_pkg;

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SL   = 4'h7;
  localparam logic [3:0] OP_SR   = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_SLT  = 4'hB;

  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    MULT   = 1'b1
  } estado_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/ula_mult.sv
// Sequential shift-add multiplier, one iteration per cycle.
module ula_mult
  import ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   i_start,
  input  logic [LARGURA-1:0]     i_a,
  input  logic [LARGURA-1:0]     i_b,
  output logic [2*LARGURA-1:0]   o_prod,
  output logic                   o_done
);

  localparam int CW = $clog2(LARGURA);

  logic [2*LARGURA-1:0] r_p;
  logic [LARGURA-1:0]   r_mcand;
  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic [2*LARGURA-1:0] w_p0;
  logic [2*LARGURA-1:0] w_prox;

  function automatic logic [2*LARGURA-1:0] passo(
    input logic [2*LARGURA-1:0] p,
    input logic [LARGURA-1:0]   m
  );
    logic [LARGURA:0] s;
    s = {1'b0, p[2*LARGURA-1:LARGURA]}
      + (p[0] ? {1'b0, m} : '0);
    return {s, p[LARGURA-1:1]};
  endfunction

  // Iteration 0 happens on the start edge, so the
  // full product is ready LARGURA edges after start.
  assign w_p0   = passo({{LARGURA{1'b0}}, i_b}, i_a);
  assign w_prox = passo(r_p, r_mcand);
  assign o_done = r_busy && (r_cnt == CW'(LARGURA - 1));
  assign o_prod = w_prox;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_mcand <= '0;
    end else if (i_start) begin
      r_p     <= w_p0;
      r_mcand <= i_a;
      r_cnt   <= CW'(1);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_p   <= w_prox;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Registered parametrised ALU with valid/ready handshake,
// full N/Z/C/V flags and a multi-cycle multiplier.
module ula_seq
  import ula_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Inicio,
  input  logic [3:0]         OP,
  input  logic [LARGURA-1:0] X,
  input  logic [LARGURA-1:0] Y,
  output logic               Pronto,
  output logic               Valido,
  output logic [LARGURA-1:0] Resultado,
  output logic               N,
  output logic               Z,
  output logic               C,
  output logic               V,
  output logic               OpInvalida
);

  localparam int DW = $clog2(LARGURA);

  estado_t              r_estado;
  logic                 r_valido;
  logic [LARGURA-1:0]   r_res;
  flags_t               r_flags;
  logic                 r_inv;

  logic                 w_aceita;
  logic                 w_ini_mul;
  logic                 w_mul_fim;
  logic [2*LARGURA-1:0] w_prod;
  logic [DW-1:0]        w_d;
  logic [LARGURA:0]     w_soma;
  logic [LARGURA:0]     w_dif;
  logic [LARGURA:0]     w_sl;
  logic [LARGURA:0]     w_sr;
  logic [LARGURA:0]     w_sra;
  logic                 w_v_add;
  logic                 w_v_sub;
  logic [LARGURA-1:0]   w_res;
  logic                 w_c;
  logic                 w_v;
  logic                 w_inv;
  flags_t               w_flags;
  flags_t               w_flags_mul;

  assign Pronto    = (r_estado == OCIOSO);
  assign w_aceita  = Inicio && Pronto;
  assign w_ini_mul = w_aceita && (OP == OP_MUL);

  ula_mult #(.LARGURA(LARGURA)) u_mult (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_start (w_ini_mul),
    .i_a     (X),
    .i_b     (Y),
    .o_prod  (w_prod),
    .o_done  (w_mul_fim)
  );

  assign w_d     = Y[DW-1:0];
  assign w_soma  = {1'b0, X} + {1'b0, Y};
  assign w_dif   = {1'b0, X} - {1'b0, Y};
  assign w_v_add = (X[LARGURA-1] == Y[LARGURA-1])
                && (w_soma[LARGURA-1] != X[LARGURA-1]);
  assign w_v_sub = (X[LARGURA-1] != Y[LARGURA-1])
                && (w_dif[LARGURA-1] != X[LARGURA-1]);

  // One guard bit catches the last bit shifted out;
  // a zero distance leaves it 0.
  assign w_sl  = {1'b0, X} << w_d;
  assign w_sr  = {X, 1'b0} >> w_d;
  assign w_sra = $unsigned($signed({X, 1'b0}) >>> w_d);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_inv = 1'b0;
    unique case (OP)
      OP_PASS: w_res = X;
      OP_ADD: begin
        w_res = w_soma[LARGURA-1:0];
        w_c   = w_soma[LARGURA];
        w_v   = w_v_add;
      end
      OP_SUB: begin
        w_res = w_dif[LARGURA-1:0];
        w_c   = w_dif[LARGURA];
        w_v   = w_v_sub;
      end
      OP_MUL: w_res = '0;
      OP_AND: w_res = X & Y;
      OP_OR:  w_res = X | Y;
      OP_XOR: w_res = X ^ Y;
      OP_SL: begin
        w_res = w_sl[LARGURA-1:0];
        w_c   = w_sl[LARGURA];
      end
      OP_SR: begin
        w_res = w_sr[LARGURA:1];
        w_c   = w_sr[0];
      end
      OP_NOT: w_res = ~X;
      OP_SRA: begin
        w_res = w_sra[LARGURA:1];
        w_c   = w_sra[0];
      end
      OP_SLT: begin
        w_res = {{(LARGURA-1){1'b0}},
                 w_dif[LARGURA-1] ^ w_v_sub};
        w_c   = w_dif[LARGURA];
        w_v   = w_v_sub;
      end
      default: w_inv = 1'b1;
    endcase
  end

  always_comb begin
    w_flags.n = w_res[LARGURA-1];
    w_flags.z = (w_res == '0);
    w_flags.c = w_c;
    w_flags.v = w_v;
    w_flags_mul.n = w_prod[LARGURA-1];
    w_flags_mul.z = (w_prod[LARGURA-1:0] == '0);
    w_flags_mul.c = |w_prod[2*LARGURA-1:LARGURA];
    w_flags_mul.v = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_estado <= OCIOSO;
      r_valido <= 1'b0;
      r_res    <= '0;
      r_flags  <= '0;
      r_inv    <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      unique case (r_estado)
        OCIOSO: begin
          if (w_ini_mul) begin
            r_estado <= MULT;
          end else if (w_aceita) begin
            r_valido <= 1'b1;
            r_res    <= w_res;
            r_flags  <= w_flags;
            r_inv    <= w_inv;
          end
        end
        MULT: begin
          if (w_mul_fim) begin
            r_estado <= OCIOSO;
            r_valido <= 1'b1;
            r_res    <= w_prod[LARGURA-1:0];
            r_flags  <= w_flags_mul;
            r_inv    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Valido     = r_valido;
  assign Resultado  = r_res;
  assign N          = r_flags.n;
  assign Z          = r_flags.z;
  assign C          = r_flags.c;
  assign V          = r_flags.v;
  assign OpInvalida = r_inv;

endmodule
